// File: rtl/booth_r4_ctrl.sv
// Sequencer for a radix-4 Booth multiplier datapath: operand load, N_ITER recode/add/shift
// passes over {Q[1],Q[0],Q[-1]}, then a two-beat drive of A:Q and a one-cycle done pulse.
module booth_r4_ctrl #(
    parameter int unsigned N_ITER = 4,
    parameter int unsigned CNT_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       q_low,
    output logic             c0,
    output logic             c1,
    output logic             c2,
    output logic             c3,
    output logic             c4,
    output logic             c5,
    output logic             c6,
    output logic             c7,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned      N_STROBE  = 8;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

    // Adder control as {c3, c4}: c3 selects subtract, c4 selects 2M.
    localparam logic [1:0] OP_ADD_M  = 2'b00;
    localparam logic [1:0] OP_ADD_2M = 2'b01;
    localparam logic [1:0] OP_SUB_M  = 2'b10;
    localparam logic [1:0] OP_SUB_2M = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RECODE,
        ST_ADD,
        ST_SHIFT,
        ST_OUT_A,
        ST_OUT_Q,
        ST_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            op;
    logic [1:0]            op_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic [N_STROBE-1:0]   strobe;
    logic [N_STROBE-1:0]   strobe_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;

    // Next state, then the Moore decode of that next state so the strobes land as flops
    always_comb begin
        state_nxt  = state;
        op_nxt     = op;
        count_nxt  = count;
        strobe_nxt = '0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_nxt = '0;
                state_nxt = ST_RECODE;
            end
            ST_RECODE: begin
                state_nxt = ST_ADD;
                case (q_low)
                    3'b001, 3'b010: op_nxt    = OP_ADD_M;
                    3'b011:         op_nxt    = OP_ADD_2M;
                    3'b100:         op_nxt    = OP_SUB_2M;
                    3'b101, 3'b110: op_nxt    = OP_SUB_M;
                    default:        state_nxt = ST_SHIFT;
                endcase
            end
            ST_ADD: begin
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (count == LAST_ITER) begin
                    state_nxt = ST_OUT_A;
                end else begin
                    count_nxt = count + CNT_W'(1);
                    state_nxt = ST_RECODE;
                end
            end
            ST_OUT_A: state_nxt = ST_OUT_Q;
            ST_OUT_Q: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
        case (state_nxt)
            ST_LOAD: begin
                strobe_nxt[0] = 1'b1;
                strobe_nxt[1] = 1'b1;
            end
            ST_ADD: begin
                strobe_nxt[2] = 1'b1;
                strobe_nxt[3] = op_nxt[1];
                strobe_nxt[4] = op_nxt[0];
            end
            ST_SHIFT: strobe_nxt[5] = 1'b1;
            ST_OUT_A: strobe_nxt[6] = 1'b1;
            ST_OUT_Q: strobe_nxt[7] = 1'b1;
            ST_DONE:  done_nxt      = 1'b1;
            default:  strobe_nxt    = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            op     <= OP_ADD_M;
            count  <= '0;
            strobe <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            op     <= op_nxt;
            count  <= count_nxt;
            strobe <= strobe_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    assign c0 = strobe[0];
    assign c1 = strobe[1];
    assign c2 = strobe[2];
    assign c3 = strobe[3];
    assign c4 = strobe[4];
    assign c5 = strobe[5];
    assign c6 = strobe[6];
    assign c7 = strobe[7];

    // A cannot take the adder sum and shift in the same cycle; count stays in range
    assert property (@(posedge clk) disable iff (!reset) !(c2 && c5));
    assert property (@(posedge clk) disable iff (!reset) count <= LAST_ITER);

endmodule

// File: tb/tb_booth_r4_ctrl.sv
// Self-checking bench for booth_r4_ctrl: recode table, directed corner sequences and
// random full multiplies through a bench-side A:Q:Q[-1] datapath model.
module tb_booth_r4_ctrl;

    localparam int unsigned N_ITER = 4;
    localparam int unsigned CNT_W  = 2;
    localparam int          WIN    = 20;

    typedef struct {
        logic [2:0] q;
        bit         is_add;
        logic [1:0] op;
    } rec_vec_t;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b1;
    logic [2:0]       q_low = 3'b000;
    logic             c0, c1, c2, c3, c4, c5, c6, c7;
    logic             busy, done;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] dp_a   = '0;
    logic [7:0] dp_q   = '0;
    logic [7:0] dp_m   = '0;
    logic       dp_qm1 = 1'b0;
    logic [7:0] out_hi = '0;
    logic [7:0] out_lo = '0;

    logic [2:0] q_sched [4];
    logic [1:0] ops_q[$];
    int         addcnt_q[$];
    int         shcnt_q[$];
    int         iter_tb;

    booth_r4_ctrl #(.N_ITER(N_ITER), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .q_low (q_low),
        .c0    (c0),
        .c1    (c1),
        .c2    (c2),
        .c3    (c3),
        .c4    (c4),
        .c5    (c5),
        .c6    (c6),
        .c7    (c7),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Booth digit of multiplier pair i: -2*q[2i+1] + q[2i] + q[2i-1], with q[-1] = 0
    function automatic int booth_digit(input logic [7:0] qv, input int i);
        int lo_idx;
        int b_lo;
        lo_idx = (i == 0) ? 0 : 2 * i - 1;
        b_lo   = (i == 0) ? 0 : int'(qv[lo_idx]);
        return -2 * int'(qv[2 * i + 1]) + int'(qv[2 * i]) + b_lo;
    endfunction

    function automatic logic [1:0] op_of(input int d);
        return {(d < 0) ? 1'b1 : 1'b0, (d == 2 || d == -2) ? 1'b1 : 1'b0};
    endfunction

    // One clock: datapath reacts to the strobes that were present before the edge
    task automatic tick(input bit dp, input logic [7:0] m_in, input logic [7:0] q_in);
        logic [7:0]  s;
        logic [9:0]  addend;
        logic [18:0] acc;
        s = {c7, c6, c5, c4, c3, c2, c1, c0};
        @(posedge clk);
        #1;
        if (s[0]) begin
            dp_a   = '0;
            dp_qm1 = 1'b0;
        end
        if (s[1]) begin
            dp_m = m_in;
            dp_q = q_in;
        end
        if (s[2]) begin
            addend = s[4] ? {dp_m[7], dp_m, 1'b0} : {{2{dp_m[7]}}, dp_m};
            dp_a   = s[3] ? dp_a - addend : dp_a + addend;
        end
        if (s[5]) begin
            acc = {dp_a, dp_q, dp_qm1};
            acc = {{2{acc[18]}}, acc[18:2]};
            {dp_a, dp_q, dp_qm1} = acc;
        end
        if (s[6]) out_hi = dp_a[7:0];
        if (s[7]) out_lo = dp_q;
        if (dp) q_low = {dp_q[1:0], dp_qm1};
    endtask

    task automatic check_shifts(input string name);
        check({name, "_shift_cnt"}, 32'(shcnt_q.size()), 32'(N_ITER));
        for (int j = 0; j < shcnt_q.size() && j < int'(N_ITER); j++)
            check($sformatf("%s_shift%0d_count", name, j), 32'(shcnt_q[j]), 32'(j));
    endtask

    // Start one operation and observe a fixed window of WIN cycles after the start edge
    task automatic run_op(input bit dp, input logic [7:0] m_in, input logic [7:0] q_in,
                          input int poke_iter, input int abort_iter,
                          output int lat, output int n_done, output bit aborted);
        lat     = -1;
        n_done  = 0;
        aborted = 1'b0;
        iter_tb = 0;
        ops_q.delete();
        addcnt_q.delete();
        shcnt_q.delete();
        out_hi = '0;
        out_lo = '0;
        if (!dp) q_low = q_sched[0];
        start = 1'b1;
        tick(dp, m_in, q_in);
        start = 1'b0;
        for (int cyc = 1; cyc <= WIN; cyc++) begin
            check("c2_c5_exclusive", 32'(c2 & c5), 32'(0));
            check("op_outside_add", 32'({c3, c4} & {2{~c2}}), 32'(0));
            check($sformatf("busy_cycle%0d", cyc), 32'(busy), 32'(lat < 0));
            if (c2) begin
                ops_q.push_back({c3, c4});
                addcnt_q.push_back(int'(count));
            end
            start = (c2 && iter_tb == poke_iter) ? 1'b1 : 1'b0;
            if (c5) begin
                shcnt_q.push_back(int'(count));
                if (iter_tb == abort_iter) begin
                    reset = 1'b0;
                    #1;
                    check("abort_async_outputs",
                          32'({c0, c1, c2, c3, c4, c5, c6, c7, busy, done, count}), 32'(0));
                    @(posedge clk);
                    #1;
                    check("abort_held_outputs",
                          32'({c0, c1, c2, c3, c4, c5, c6, c7, busy, done, count}), 32'(0));
                    reset   = 1'b1;
                    start   = 1'b0;
                    aborted = 1'b1;
                    return;
                end
                iter_tb++;
                if (!dp) q_low = q_sched[(iter_tb < 4) ? iter_tb : 3];
            end
            if (done) begin
                n_done++;
                if (lat < 0) lat = cyc;
            end
            tick(dp, m_in, q_in);
        end
        start = 1'b0;
    endtask

    initial begin
        rec_vec_t   tbl [8];
        logic [1:0] exp_ops[$];
        int         exp_it[$];
        logic [7:0] fix_m [4];
        logic [7:0] fix_q [4];
        logic [7:0] mv;
        logic [7:0] qv;
        logic [15:0] exp_p;
        int lat;
        int nd;
        int d;
        bit ab;

        tbl[0] = '{3'b000, 1'b0, 2'b00};
        tbl[1] = '{3'b001, 1'b1, 2'b00};
        tbl[2] = '{3'b010, 1'b1, 2'b00};
        tbl[3] = '{3'b011, 1'b1, 2'b01};
        tbl[4] = '{3'b100, 1'b1, 2'b11};
        tbl[5] = '{3'b101, 1'b1, 2'b10};
        tbl[6] = '{3'b110, 1'b1, 2'b10};
        tbl[7] = '{3'b111, 1'b0, 2'b00};
        fix_m  = '{8'h07, 8'h80, 8'h7F, 8'hFF};
        fix_q  = '{8'hFD, 8'h80, 8'h80, 8'h01};

        // Reset held with start high
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({c0, c1, c2, c3, c4, c5, c6, c7, busy, done, count}), 32'(0));
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_release", 32'({c0, c1, c2, c3, c4, c5, c6, c7, busy, done, count}), 32'(0));

        // Recode table: q_low held constant for all iterations
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) q_sched[j] = tbl[i].q;
            run_op(1'b0, 8'h00, 8'h00, -1, -1, lat, nd, ab);
            check($sformatf("tbl%0d_latency", i), 32'(lat), tbl[i].is_add ? 32'd16 : 32'd12);
            check($sformatf("tbl%0d_done_pulses", i), 32'(nd), 32'(1));
            check($sformatf("tbl%0d_add_cycles", i), 32'(ops_q.size()), tbl[i].is_add ? 32'd4 : 32'd0);
            for (int j = 0; j < ops_q.size(); j++)
                check($sformatf("tbl%0d_op%0d", i, j), 32'(ops_q[j]), 32'(tbl[i].op));
            check_shifts($sformatf("tbl%0d", i));
        end

        // Per-iteration recode sequence 011, 100, 101, 001
        q_sched = '{3'b011, 3'b100, 3'b101, 3'b001};
        run_op(1'b0, 8'h00, 8'h00, -1, -1, lat, nd, ab);
        check("seq_latency", 32'(lat), 32'd16);
        check("seq_add_cycles", 32'(ops_q.size()), 32'd4);
        exp_ops = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int j = 0; j < ops_q.size() && j < 4; j++) begin
            check($sformatf("seq_op%0d", j), 32'(ops_q[j]), 32'(exp_ops[j]));
            check($sformatf("seq_add_count%0d", j), 32'(addcnt_q[j]), 32'(j));
        end
        check_shifts("seq");

        // Start pulse during ADD of iteration 2 is ignored
        for (int j = 0; j < 4; j++) q_sched[j] = 3'b011;
        run_op(1'b0, 8'h00, 8'h00, 2, -1, lat, nd, ab);
        check("ignstart_latency", 32'(lat), 32'd16);
        check("ignstart_done_pulses", 32'(nd), 32'(1));
        check_shifts("ignstart");

        // Reset during SHIFT of iteration 1, then a clean operation
        for (int j = 0; j < 4; j++) q_sched[j] = 3'b000;
        run_op(1'b0, 8'h00, 8'h00, -1, 1, lat, nd, ab);
        check("abort_reached", 32'(ab), 32'(1));
        check("abort_no_done", 32'(nd), 32'(0));
        run_op(1'b0, 8'h00, 8'h00, -1, -1, lat, nd, ab);
        check("post_abort_latency", 32'(lat), 32'd12);
        check_shifts("post_abort");

        // Start held high through DONE: IDLE for one cycle, then LOAD again
        q_low = 3'b000;
        start = 1'b1;
        lat   = -1;
        for (int cyc = 1; cyc <= WIN && lat < 0; cyc++) begin
            tick(1'b0, 8'h00, 8'h00);
            if (done) lat = cyc;
        end
        check("held_latency", 32'(lat), 32'd12);
        tick(1'b0, 8'h00, 8'h00);
        check("held_idle_gap", 32'({busy, c0, c1}), 32'(0));
        tick(1'b0, 8'h00, 8'h00);
        check("held_reload", 32'({busy, c0, c1}), 32'b111);
        start = 1'b0;
        repeat (WIN) tick(1'b0, 8'h00, 8'h00);

        // Full multiplies through the datapath model: fixed corners, then random operands
        for (int t = 0; t < 28; t++) begin
            mv = (t < 4) ? fix_m[t] : 8'($urandom);
            qv = (t < 4) ? fix_q[t] : 8'($urandom);
            exp_p = 16'(int'($signed(mv)) * int'($signed(qv)));
            exp_ops.delete();
            exp_it.delete();
            for (int i = 0; i < int'(N_ITER); i++) begin
                d = booth_digit(qv, i);
                if (d != 0) begin
                    exp_ops.push_back(op_of(d));
                    exp_it.push_back(i);
                end
            end
            run_op(1'b1, mv, qv, -1, -1, lat, nd, ab);
            check($sformatf("mul%0d_%02h_x_%02h_product", t, mv, qv), 32'({out_hi, out_lo}), 32'(exp_p));
            check($sformatf("mul%0d_latency", t), 32'(lat), 32'(12 + exp_ops.size()));
            check($sformatf("mul%0d_done_pulses", t), 32'(nd), 32'(1));
            check($sformatf("mul%0d_add_cycles", t), 32'(ops_q.size()), 32'(exp_ops.size()));
            for (int j = 0; j < ops_q.size() && j < exp_ops.size(); j++) begin
                check($sformatf("mul%0d_op%0d", t, j), 32'(ops_q[j]), 32'(exp_ops[j]));
                check($sformatf("mul%0d_add_count%0d", t, j), 32'(addcnt_q[j]), 32'(exp_it[j]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_r4_ctrl.md
Name: booth_r4_ctrl

Overview:
Control unit sequencing the radix-4 Booth multiplier datapath: reg_A (accumulator), reg_Q/Q[-1], reg_M, the adder/subtractor and the output bus. On start it loads the operands, runs N_ITER recode/add/shift iterations from the 3 LSBs of Q:Q[-1], then drives the result out in two beats and pulses done. Moore FSM with one-hot-style control strobes c0..c7 feeding the datapath registers.

Parameters:
N_ITER, 4, number of radix-4 iterations (operand width / 2; 8-bit operands -> 4)
CNT_W, 2, iteration counter width; must satisfy 2^CNT_W >= N_ITER

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a multiplication; sampled only in IDLE
q_low  input  3  {Q[1], Q[0], Q[-1]} from the datapath
c0  output  1  init: clear A and Q[-1]
c1  output  1  load M and Q from input bus
c2  output  1  load A from adder sum
c3  output  1  adder op: 0 add, 1 subtract
c4  output  1  adder operand: 0 M, 1 2M
c5  output  1  arithmetic shift right by 2 of A:Q:Q[-1]
c6  output  1  drive A (high half) onto output bus
c7  output  1  drive Q (low half) onto output bus
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, result fully output
count  output  CNT_W  current iteration index

Behaviour:
- States: IDLE, LOAD, RECODE, ADD, SHIFT, OUT_A, OUT_Q, DONE. Outputs are decoded from the state register and op register only (no input-to-output paths).
- Reset (reset=0, async): state=IDLE, count=0, op register={c3,c4}=00; all strobes, busy, done = 0. Reset mid-operation aborts immediately; no further strobes until a new start.
- IDLE: all strobes 0. start=1 -> LOAD; else stay.
- LOAD (1 cycle): c0=1, c1=1; count<=0 -> RECODE.
- RECODE (1 cycle): no strobes; sample q_low and recode:
  000, 111 -> no add, go SHIFT
  001, 010 -> +M: op<=00, go ADD
  011 -> +2M: op<=01, go ADD
  100 -> -2M: op<=11, go ADD
  101, 110 -> -M: op<=10, go ADD
- ADD (1 cycle): c2=1; c3, c4 from op register -> SHIFT. c3/c4 are 0 in every state other than ADD.
- SHIFT (1 cycle): c5=1; if count==N_ITER-1 -> OUT_A, count held; else count<=count+1 -> RECODE.
- OUT_A: c6=1 -> OUT_Q: c7=1 -> DONE: done=1 -> IDLE.
- Latency start-sample to done: 1 + sum(iterations: 2 no-add, 3 add) + 3 cycles. N_ITER=4: min 12, max 16 clock cycles after the start-sampling edge.
- start while busy (any state other than IDLE, including DONE) is ignored, not queued. start held high through DONE causes a new LOAD on the cycle after DONE returns to IDLE.
- Exactly one of c0..c2, c5..c7 group active per state (c0+c1 together in LOAD only); never c2 and c5 in the same cycle.
- count never exceeds N_ITER-1; no wrap during an operation.

Test Plan:
- Reset: hold reset=0 with start=1 for 3 cycles -> state IDLE, all c0..c7=0, busy=0, done=0, count=0.
- All-skip: start pulse, q_low=000 throughout -> LOAD(c0,c1), then 4x {RECODE, SHIFT(c5)}, OUT_A(c6), OUT_Q(c7), done pulse 12 cycles after start edge; c2 never high.
- Recode table: per iteration drive q_low=011, 100, 101, 001 -> ADD cycles show {c3,c4} = 01, 11, 10, 00 with c2=1; done at cycle 16; count sequence 0,1,2,3.
- Full multiply with datapath model: M=7, Q=-3 (8-bit) -> strobe sequence yields output bus A:Q = 16'hFFEB (-21) over c6/c7 beats.
- Ignored start: pulse start during ADD of iteration 2 -> no restart, count continues 2->3, single done pulse.
- Reset mid-op: assert reset=0 during SHIFT of iteration 1 -> strobes drop asynchronously, state IDLE; new start then completes normally with count restarting at 0.
